// File: rtl/arinc_rd_sched_if.sv
// Output word stream of the ARINC-429 read-out scheduler: reassembled word, its
// channel/word coordinates and parity flag, with a valid/ready handshake.
interface arinc_rd_sched_if;
    logic [31:0] out_data;
    logic [2:0]  out_ch;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_perr;

    modport master (
        output out_data, out_ch, out_idx, out_valid, out_perr,
        input  out_ready
    );

    modport slave (
        input  out_data, out_ch, out_idx, out_valid, out_perr,
        output out_ready
    );
endinterface

// File: rtl/arinc_rd_sched.sv
// Sweeps N_CH ARINC-429 receiver RAMs word by word, rebuilds 32-bit words from two
// half-word reads and streams them out. Optional parity check: ARINC_PARITY_CHK_EN.
module arinc_rd_sched #(
    parameter int N_CH   = 4,
    parameter int WORDS  = 16,
    parameter int RD_LAT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sec,
    output logic [4:0]           rdaddress,
    input  logic [16*N_CH-1:0]   ch_q,
    arinc_rd_sched_if.master     out_if,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 overrun
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [2:0]       LAST_CH  = 3'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD_LO, S_RD_HI, S_PRESENT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_ch;
    logic [15:0]      r_lo;
    logic [31:0]      r_data;
    logic [4:0]       r_rdaddress;
    logic             r_sweep_done;
    logic             r_overrun;
    logic             w_valid;
    logic             w_busy;

    wire logic [15:0]      w_sel      = ch_q[16*int'(r_ch) +: 16];
    wire logic             w_cnt_done = (r_cnt == CNT_END);
    wire logic             w_idx_last = (r_idx == LAST_IDX);
    wire logic             w_last     = w_idx_last && (r_ch == LAST_CH);
    wire logic [IDX_W-1:0] w_idx_nxt  = w_idx_last ? '0 : r_idx + 1'b1;
    wire logic [2:0]       w_ch_nxt   = w_idx_last ? r_ch + 3'd1 : r_ch;

    // NOTE: state-holding elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin : state_reg
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin : next_state
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (sec)              w_next = S_RD_LO;
            S_RD_LO:   if (w_cnt_done)       w_next = S_RD_HI;
            S_RD_HI:   if (w_cnt_done)       w_next = S_PRESENT;
            S_PRESENT: if (out_if.out_ready) w_next = w_last ? S_IDLE : S_RD_LO;
            default:                         w_next = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        w_valid = (r_state == S_PRESENT);
        w_busy  = (r_state != S_IDLE);
    end

    // Read address only moves on state entry, so RAM data stays stable through waits and stalls.
    always_ff @(posedge clock) begin : datapath
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_ch         <= '0;
            r_lo         <= '0;
            r_data       <= '0;
            r_rdaddress  <= '0;
            r_sweep_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            r_overrun    <= sec && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: if (sec) begin
                    r_ch        <= '0;
                    r_idx       <= '0;
                    r_cnt       <= '0;
                    r_rdaddress <= '0;
                end
                S_RD_LO: begin
                    if (w_cnt_done) begin
                        r_lo        <= w_sel;
                        r_cnt       <= '0;
                        r_rdaddress <= {4'(r_idx), 1'b1};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_HI: begin
                    if (w_cnt_done) begin
                        r_data <= {w_sel, r_lo};
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESENT: if (out_if.out_ready) begin
                    if (w_last) begin
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_idx       <= w_idx_nxt;
                        r_ch        <= w_ch_nxt;
                        r_rdaddress <= {4'(w_idx_nxt), 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARINC_PARITY_CHK_EN
    logic r_perr;
    // Flags a word whose 32 bits fail ARINC odd parity; captured alongside out_data.
    always_ff @(posedge clock) begin : parity
        if (reset)                              r_perr <= 1'b0;
        else if (r_state == S_RD_HI && w_cnt_done) r_perr <= ~^{w_sel, r_lo};
    end
    assign out_if.out_perr = r_perr;
`else
    assign out_if.out_perr = 1'b0;
`endif

    assign rdaddress        = r_rdaddress;
    assign out_if.out_data  = r_data;
    assign out_if.out_ch    = r_ch;
    assign out_if.out_idx   = 4'(r_idx);
    assign out_if.out_valid = w_valid;
    assign busy             = w_busy;
    assign sweep_done       = r_sweep_done;
    assign overrun          = r_overrun;
endmodule

// File: tb/tb_arinc_rd_sched.sv
// Self-checking bench for arinc_rd_sched: RAM model, scoreboard of expected words,
// stall/overrun/reset scenarios. Parity expectations follow ARINC_PARITY_CHK_EN.
module tb_arinc_rd_sched;
    localparam int N_CH   = 4;
    localparam int WORDS  = 16;
    localparam int RD_LAT = 2;
    localparam int NW     = N_CH * WORDS;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  ch;
        logic [3:0]  idx;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               sec;
    logic [4:0]         rdaddress;
    logic [16*N_CH-1:0] ch_q;
    logic               busy;
    logic               sweep_done;
    logic               overrun;

    arinc_rd_sched_if bus ();

    arinc_rd_sched #(.N_CH(N_CH), .WORDS(WORDS), .RD_LAT(RD_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .sec        (sec),
        .rdaddress  (rdaddress),
        .ch_q       (ch_q),
        .out_if     (bus),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [N_CH][WORDS];
    logic [4:0]  addr_d;
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;

    // RAM model: read data follows the address one clock later.
    always @(posedge clock) addr_d <= rdaddress;

    always_comb begin
        ch_q = '0;
        for (int c = 0; c < N_CH; c++)
            ch_q[16*c +: 16] = addr_d[0] ? mem[c][addr_d[4:1]][31:16] : mem[c][addr_d[4:1]][15:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [31:0] d);
`ifdef ARINC_PARITY_CHK_EN
        return ~^d;
`else
        return 1'b0;
`endif
    endfunction

    logic        done_due = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_ch;
    logic [3:0]  prev_idx;
    logic [4:0]  prev_addr;

    always @(negedge clock) begin : monitor
        exp_t e;
        logic last_now;
        last_now = 1'b0;
        if (reset) begin
            done_due   <= 1'b0;
            stall_prev <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_ch", 32'(bus.out_ch), 32'(e.ch));
                    check("out_idx", 32'(bus.out_idx), 32'(e.idx));
                    check("out_perr", 32'(bus.out_perr), 32'(exp_perr(e.data)));
                    last_now = (e.ch == 3'(N_CH - 1)) && (e.idx == 4'(WORDS - 1));
                end
                n_acc <= n_acc + 1;
            end
            check("sweep_done", 32'(sweep_done), 32'(done_due));
            if (stall_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_ch", 32'(bus.out_ch), 32'(prev_ch));
                check("stall_idx", 32'(bus.out_idx), 32'(prev_idx));
                check("stall_addr", 32'(rdaddress), 32'(prev_addr));
            end
            done_due   <= last_now;
            stall_prev <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
            prev_ch    <= bus.out_ch;
            prev_idx   <= bus.out_idx;
            prev_addr  <= rdaddress;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < WORDS; i++) begin
                e.data = mem[c][i];
                e.ch   = 3'(c);
                e.idx  = 4'(i);
                sb.push_back(e);
            end
        n_acc = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdaddress"}, 32'(rdaddress), 32'd0);
        check({tag, "_data"}, bus.out_data, 32'd0);
        check({tag, "_ch"}, 32'(bus.out_ch), 32'd0);
        check({tag, "_idx"}, 32'(bus.out_idx), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_perr"}, 32'(bus.out_perr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_words"}, 32'(n_acc), 32'(NW));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Waits (bounded) until the given word is presented; returns at first visibility.
    task automatic wait_word(input string tag, input int ch, input int idx);
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_ch == 3'(ch) && bus.out_idx == 4'(idx)) && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_found"}, 32'(bus.out_valid && bus.out_ch == 3'(ch) && bus.out_idx == 4'(idx)), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset         = 1'b1;
        sec           = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < WORDS; i++)
                mem[c][i] = {8'(c + 16), 8'(i * 3), 8'(8'hA5 ^ i), 8'(c * 16 + i)};
        mem[0][0] = 32'h8000_0001;
        mem[1][0] = 32'h0000_0000;
        mem[1][1] = 32'h0000_0001;

        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // First word latency, then a 10-clock stall at ch0/idx3 in the same sweep.
        push_sweep();
        sec = 1'b1;
        tick();
        sec = 1'b0;
        check("busy_after_sec", 32'(busy), 32'd1);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_latency", 32'(n), 32'd5);
        check("first_data", bus.out_data, 32'h8000_0001);
        check("first_ch", 32'(bus.out_ch), 32'd0);
        check("first_idx", 32'(bus.out_idx), 32'd0);
        wait_word("stall", 0, 3);
        bus.out_ready = 1'b0;
        repeat (10) tick();
        check("stall_hold_idx", 32'(bus.out_idx), 32'd3);
        bus.out_ready = 1'b1;
        wait_idle("sweep1", 2000);

        // sec mid-sweep and sec coinciding with the final accept: overrun, no restart.
        push_sweep();
        sec = 1'b1;
        tick();
        sec = 1'b0;
        repeat (100) tick();
        sec = 1'b1;
        tick();
        sec = 1'b0;
        check("overrun_mid", 32'(overrun), 32'd1);
        check("busy_mid", 32'(busy), 32'd1);
        tick();
        check("overrun_clear", 32'(overrun), 32'd0);
        wait_word("last", N_CH - 1, WORDS - 1);
        sec = 1'b1;
        tick();
        sec = 1'b0;
        check("overrun_final", 32'(overrun), 32'd1);
        check("no_restart_busy", 32'(busy), 32'd0);
        wait_idle("sweep2", 2000);
        repeat (5) tick();
        check("still_idle", 32'(busy), 32'd0);

        // Reset while reading the high half-word of ch1 idx0.
        push_sweep();
        sec = 1'b1;
        tick();
        sec = 1'b0;
        n = 0;
        while (!(bus.out_ch == 3'd1 && rdaddress[0] && !bus.out_valid) && n < 1000) begin
            tick();
            n++;
        end
        check("rd_hi_found", 32'(bus.out_ch == 3'd1 && rdaddress[0] && !bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        sb.delete();
        reset = 1'b0;
        tick();
        push_sweep();
        sec = 1'b1;
        tick();
        sec = 1'b0;
        repeat (4) tick();
        check("restart_valid", 32'(bus.out_valid), 32'd1);
        check("restart_ch", 32'(bus.out_ch), 32'd0);
        check("restart_idx", 32'(bus.out_idx), 32'd0);
        wait_idle("sweep3", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
